// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data responder.
// Used by dmem_responder and its storage sub-module dmem_array.
package dmem_pkg;

  localparam int OFF_W  = 3;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 doubleword storage: synchronous write, registered read every cycle.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one request at a time, WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN flags non-doubleword-aligned addresses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rd_ok_q;

  logic              req_err;
  logic              access_wait;
  logic              arr_we;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign req_idx = req_addr[OFF_W +: IDX_W];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = (|req_addr[DATA_W-1:OFF_W+IDX_W]) | (|req_addr[OFF_W-1:0]);
`else
  logic unused_offset;
  assign unused_offset = ^req_addr[OFF_W-1:0];
  assign req_err       = |req_addr[DATA_W-1:OFF_W+IDX_W];
`endif

  assign access_wait = (state_q == WAIT) && (cnt_q == LAST_CNT);

  // With no wait states the access happens on the acceptance edge, straight from the inputs.
  always_comb begin
    arr_we    = 1'b0;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    if (resetl) begin
      if (WAIT_CYCLES == 0) begin
        if (state_q == IDLE && req_valid) begin
          arr_idx   = req_idx;
          arr_wdata = req_wdata;
          arr_we    = req_write && !req_err;
        end
      end else if (access_wait) begin
        arr_we = wr_q && !err_q;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .CLK   (CLK),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            err_q       <= req_err;
            idx_q       <= req_idx;
            wdata_q     <= req_wdata;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_err;
              rd_ok_q     <= !req_write && !req_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rd_ok_q     <= !wr_q && !err_q;
          end
        end
        RESP: begin
          // Array index is held and no writes occur here, so read data stays stable.
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2/DEPTH=128 and WAIT_CYCLES=0/DEPTH=16),
// vector table, hand sequences and random traffic against an array-based reference model.
module tb_dmem_responder;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic             CLK;
  logic             resetl;
  logic [1:0]       rv, rw, rr, qr, sv, se;
  logic [1:0][63:0] ra, rwd, sd;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl [2][128];

  dmem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) u_dut_w2 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(rv[0]), .req_ready(qr[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
    .rsp_valid(sv[0]), .rsp_ready(rr[0]), .rsp_rdata(sd[0]), .rsp_err(se[0])
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(rv[1]), .req_ready(qr[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
    .rsp_valid(sv[1]), .rsp_ready(rr[1]), .rsp_rdata(sd[1]), .rsp_err(se[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int depof(input int d);
    return (d == 0) ? 128 : 16;
  endfunction

  function automatic int wcof(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [63:0] pat(input int d, input int i);
    return {32'hA5A5_0000 | 32'(d), 32'(i) * 32'h0101_0101};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed doubleword memory with range (and optional alignment) rule.
  function automatic void model(input int d, input bit wr, input logic [63:0] addr,
                                input logic [63:0] wdata, output logic [63:0] erd,
                                output logic eerr);
    logic [63:0] lim;
    lim  = 64'(depof(d)) * 64'd8;
    eerr = (addr >= lim);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((addr % 64'd8) != 64'd0) eerr = 1'b1;
`endif
    erd = '0;
    if (!eerr) begin
      if (wr) mdl[d][int'(addr >> 3)] = wdata;
      else    erd = mdl[d][int'(addr >> 3)];
    end
  endfunction

  task automatic garbage(input int d);
    rv[d]  = 1'($urandom);
    rw[d]  = 1'($urandom);
    ra[d]  = {$urandom, $urandom};
    rwd[d] = {$urandom, $urandom};
  endtask

  // One transaction; drives junk on req_* while busy, holds rsp_ready low for `hold` cycles.
  task automatic txn(input int d, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                     input int hold, output logic [63:0] rd, output logic er, output time t_acc);
    int lat;
    chk("req_ready_idle", 64'(qr[d]), 64'd1);
    rv[d] = 1'b1; rw[d] = wr; ra[d] = addr; rwd[d] = wdata; rr[d] = 1'b0;
    @(posedge CLK);
    t_acc = $time;
    #1;
    lat = 1;
    while (sv[d] !== 1'b1 && lat <= 40) begin
      chk("req_ready_wait", 64'(qr[d]), 64'd0);
      garbage(d);
      @(posedge CLK); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(wcof(d) + 1));
    rd = sd[d];
    er = se[d];
    for (int i = 0; i < hold; i++) begin
      garbage(d);
      rr[d] = 1'b0;
      @(posedge CLK); #1;
      chk("hold_valid", 64'(sv[d]), 64'd1);
      chk("hold_rdata", sd[d], rd);
      chk("hold_err", 64'(se[d]), 64'(er));
      chk("hold_req_ready", 64'(qr[d]), 64'd0);
    end
    rv[d] = 1'b0;
    rr[d] = 1'b1;
    @(posedge CLK); #1;
    rr[d] = 1'b0;
    chk("rsp_valid_drop", 64'(sv[d]), 64'd0);
    chk("req_ready_back", 64'(qr[d]), 64'd1);
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_req_ready", 64'(qr[d]), 64'd1);
    chk("rst_rsp_valid", 64'(sv[d]), 64'd0);
    chk("rst_rsp_rdata", sd[d], 64'd0);
    chk("rst_rsp_err", 64'(se[d]), 64'd0);
  endtask

  initial begin
    vec_t        vt[11];
    logic [63:0] rd, erd, addr, wdata;
    logic        er, eerr;
    time         t0, t1, t2;
    bit          wr;
    int          d, r;

    resetl = 1'b0; rv = '0; rw = '0; rr = '0; ra = '0; rwd = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    resetl = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < depof(k); i++) begin
        txn(k, 1'b1, 64'(i) * 64'd8, pat(k, i), 0, rd, er, t0);
        mdl[k][i] = pat(k, i);
      end
    end

    vt[0]  = '{1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 64'h10, 64'h0, 5, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vt[2]  = '{1'b0, 64'h400, 64'h0, 2, 64'h0, 1'b1};
    vt[3]  = '{1'b1, 64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, 1'b1};
    vt[4]  = '{1'b0, 64'h0, 64'h0, 0, pat(0, 0), 1'b0};
    vt[7]  = '{1'b0, 64'h3F8, 64'h0, 1, pat(0, 127), 1'b0};
    vt[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 64'h0, 1'b1};
`ifdef DMEM_ALIGN_CHECK_EN
    vt[5]  = '{1'b1, 64'h0C, 64'h01234567_89ABCDEF, 0, 64'h0, 1'b1};
    vt[6]  = '{1'b0, 64'h08, 64'h0, 0, pat(0, 1), 1'b0};
    vt[8]  = '{1'b1, 64'h3FF, 64'h55AA_55AA_0F0F_0F0F, 0, 64'h0, 1'b1};
    vt[9]  = '{1'b0, 64'h3F8, 64'h0, 0, pat(0, 127), 1'b0};
`else
    vt[5]  = '{1'b1, 64'h0C, 64'h01234567_89ABCDEF, 0, 64'h0, 1'b0};
    vt[6]  = '{1'b0, 64'h08, 64'h0, 0, 64'h01234567_89ABCDEF, 1'b0};
    vt[8]  = '{1'b1, 64'h3FF, 64'h55AA_55AA_0F0F_0F0F, 0, 64'h0, 1'b0};
    vt[9]  = '{1'b0, 64'h3F8, 64'h0, 0, 64'h55AA_55AA_0F0F_0F0F, 1'b0};
`endif

    for (int k = 0; k < 11; k++) begin
      txn(0, vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].hold, rd, er, t0);
      chk($sformatf("vec%0d_rdata", k), rd, vt[k].exp_rd);
      chk($sformatf("vec%0d_err", k), 64'(er), 64'(vt[k].exp_err));
      model(0, vt[k].wr, vt[k].addr, vt[k].wdata, erd, eerr);
    end

    // Reset during the access cycle of WAIT: the store must be discarded.
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h8; rwd[0] = 64'h1234;
    @(posedge CLK); #1;
    rv[0] = 1'b0;
    @(posedge CLK); #1;
    resetl = 1'b0;
    @(posedge CLK); #1;
    chk_reset_vals(0);
    resetl = 1'b1;
    txn(0, 1'b0, 64'h8, 64'h0, 0, rd, er, t0);
    chk("rst_abort_rdata", rd, mdl[0][1]);
    chk("rst_abort_err", 64'(er), 64'd0);

    // Zero-wait instance: back-to-back requests every 2 cycles.
    txn(1, 1'b0, 64'h18, 64'h0, 0, rd, er, t0);
    chk("w0_load_rdata", rd, mdl[1][3]);
    txn(1, 1'b1, 64'h20, 64'h7777_0000_1111_2222, 0, rd, er, t1);
    model(1, 1'b1, 64'h20, 64'h7777_0000_1111_2222, erd, eerr);
    txn(1, 1'b0, 64'h20, 64'h0, 0, rd, er, t2);
    chk("w0_store_load", rd, 64'h7777_0000_1111_2222);
    chk("w0_spacing_a", 64'(t1 - t0), 64'd20);
    chk("w0_spacing_b", 64'(t2 - t1), 64'd20);
    txn(1, 1'b0, 64'h80, 64'h0, 0, rd, er, t0);
    chk("w0_oor_err", 64'(er), 64'd1);
    chk("w0_oor_rdata", rd, 64'd0);

    for (int n = 0; n < 200; n++) begin
      d     = int'($urandom_range(0, 1));
      wr    = 1'($urandom);
      wdata = {$urandom, $urandom};
      r     = int'($urandom_range(0, 9));
      if (r == 0)      addr = 64'(depof(d) * 8) + 64'($urandom_range(0, 4095));
      else if (r == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else if (r < 6)  addr = 64'($urandom_range(0, depof(d) - 1)) * 64'd8;
      else             addr = 64'($urandom_range(0, depof(d) * 8 - 1));
      model(d, wr, addr, wdata, erd, eerr);
      txn(d, wr, addr, wdata, int'($urandom_range(0, 3)), rd, er, t0);
      chk($sformatf("rand%0d_rdata", n), rd, erd);
      chk($sformatf("rand%0d_err", n), 64'(er), 64'(eerr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
